pe_mac_db: RTL and testbench

- Second-generation systolic processing element for the Gemma matmul array, with parametrised operand and accumulator width.
- Per-cycle runtime signed/unsigned operand mode, optional registered multiplier stage, and optional saturating accumulation.
- Double-buffered result: a tile-end marker moves the finished sum into a hold register while the next tile accumulates with no bubble.
- Hold registers in a column form a shift chain that drains results southward to the array's output collector.

---
 rtl/pe_pkg.sv | 34 +++
 rtl/pe_mac_db_sat_add.sv | 35 +++
 rtl/pe_mac_db.sv | 183 ++++++++++++++++++
 tb/tb_pe_mac_db.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared constants and helpers for the pe_mac_db systolic processing element.
// Saturation bounds are returned at a fixed maximum width; callers slice to ACCUM_WIDTH.
package pe_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 8;
    localparam int DEFAULT_ACCUM_WIDTH = 32;
    localparam int DEFAULT_PIPE_MUL    = 1;
    localparam int MAX_ACCUM_WIDTH     = 128;

    // Cycles from an operand pair entering the PE to its capture into the hold register.
    localparam int MAC_LATENCY = 1 + DEFAULT_PIPE_MUL;

    typedef logic [MAX_ACCUM_WIDTH-1:0] bound_t;

    typedef enum logic {
        MODE_UNSIGNED = 1'b0,
        MODE_SIGNED   = 1'b1
    } op_mode_e;

    localparam bound_t BOUND_ONE = bound_t'(1'b1);

    function automatic bound_t sat_max(input int aw);
        return (BOUND_ONE << (aw - 1)) - BOUND_ONE;
    endfunction

    function automatic bound_t sat_min(input int aw);
        return BOUND_ONE << (aw - 1);
    endfunction

    function automatic int mac_latency(input int pipe_mul);
        return 1 + pipe_mul;
    endfunction

endpackage

// File: rtl/pe_mac_db_sat_add.sv
// Combinational ACCUM_WIDTH signed adder with optional clamp to the signed range.
// overflow reports the unclamped sum leaving the signed range, whatever SATURATE is.
module sat_add
    import pe_pkg::*;
#(
    parameter int AW       = DEFAULT_ACCUM_WIDTH,
    parameter int SATURATE = 1
) (
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] b,
    output logic [AW-1:0] sum,
    output logic          overflow
);

    localparam bound_t MAX_B = sat_max(AW);
    localparam bound_t MIN_B = sat_min(AW);

    logic [AW:0] wide_s;

    // One guard bit; overflow when the guard and sign bits disagree.
    always_comb begin
        wide_s   = {a[AW-1], a} + {b[AW-1], b};
        overflow = wide_s[AW] ^ wide_s[AW-1];
        if ((SATURATE != 0) && overflow) begin
            if (wide_s[AW]) begin
                sum = MIN_B[AW-1:0];
            end else begin
                sum = MAX_B[AW-1:0];
            end
        end else begin
            sum = wide_s[AW-1:0];
        end
    end

endmodule

// File: rtl/pe_mac_db.sv
// Double-buffered systolic MAC processing element: accumulates a tile while the
// previous tile's result waits in a hold register that doubles as a drain-chain stage.
module pe_mac_db
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int ACCUM_WIDTH = DEFAULT_ACCUM_WIDTH,
    parameter int PIPE_MUL    = DEFAULT_PIPE_MUL,
    parameter int SATURATE    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   accum_reset,
    input  logic                   valid,
    input  logic                   last,
    input  logic                   signed_mode,
    input  logic [DATA_WIDTH-1:0]  inp_north,
    input  logic [DATA_WIDTH-1:0]  inp_west,
    output logic [DATA_WIDTH-1:0]  outp_south,
    output logic [DATA_WIDTH-1:0]  outp_east,
    output logic                   valid_out,
    output logic                   last_out,
    output logic                   signed_out,
    input  logic [ACCUM_WIDTH-1:0] drain_in,
    input  logic                   drain_in_valid,
    input  logic                   shift_en,
    output logic [ACCUM_WIDTH-1:0] drain_out,
    output logic                   drain_out_valid,
    output logic                   sat_flag,
    output logic                   overrun
);

    localparam int DW = DATA_WIDTH;
    localparam int AW = ACCUM_WIDTH;
    localparam int EW = AW + 1;

    logic [AW-1:0] mul_prod_s;
    logic [AW-1:0] st_prod_s;
    logic          st_valid_s;
    logic          st_last_s;
    logic [AW-1:0] sum_s;
    logic          ovf_s;
    logic          capture_s;

    logic [AW-1:0] acc_r;
    logic [AW-1:0] hold_r;
    logic          hold_valid_r;
    logic          sat_flag_r;
    logic          overrun_r;
    logic [DW-1:0] south_r;
    logic [DW-1:0] east_r;
    logic          valid_fwd_r;
    logic          last_fwd_r;
    logic          signed_fwd_r;

    // Extending by one bit past AW keeps the unsigned product non-negative;
    // the slice then gives the sign/zero-extended product at accumulator width.
    function automatic logic [AW-1:0] ext_product(
        input logic [DW-1:0] op_a,
        input logic [DW-1:0] op_b,
        input logic          mode
    );
        logic signed [EW-1:0] ea;
        logic signed [EW-1:0] eb;
        logic signed [EW-1:0] pr;
        logic                 sign_en;
        sign_en = (mode == MODE_SIGNED);
        ea = signed'({{(EW-DW){sign_en & op_a[DW-1]}}, op_a});
        eb = signed'({{(EW-DW){sign_en & op_b[DW-1]}}, op_b});
        pr = ea * eb;
        return pr[AW-1:0];
    endfunction

    assign mul_prod_s = ext_product(inp_north, inp_west, signed_mode);

    generate
        if (PIPE_MUL != 0) begin : g_pipe
            logic [AW-1:0] p_prod_r;
            logic          p_valid_r;
            logic          p_last_r;

            // Multiplier stage; accum_reset flushes it so no in-flight product survives.
            always_ff @(posedge clk) begin
                if (rst || accum_reset) begin
                    p_prod_r  <= {AW{1'b0}};
                    p_valid_r <= 1'b0;
                    p_last_r  <= 1'b0;
                end else begin
                    p_prod_r  <= mul_prod_s;
                    p_valid_r <= valid;
                    p_last_r  <= valid & last;
                end
            end

            assign st_prod_s  = p_prod_r;
            assign st_valid_s = p_valid_r;
            assign st_last_s  = p_last_r;
        end else begin : g_direct
            assign st_prod_s  = mul_prod_s;
            assign st_valid_s = valid;
            assign st_last_s  = valid & last;
        end
    endgenerate

    sat_add #(
        .AW       (AW),
        .SATURATE (SATURATE)
    ) u_sat_add (
        .a        (acc_r),
        .b        (st_prod_s),
        .sum      (sum_s),
        .overflow (ovf_s)
    );

    assign capture_s = st_valid_s & st_last_s & ~accum_reset;

    // Systolic forwarding of operands and sideband, independent of valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            south_r      <= {DW{1'b0}};
            east_r       <= {DW{1'b0}};
            valid_fwd_r  <= 1'b0;
            last_fwd_r   <= 1'b0;
            signed_fwd_r <= 1'b0;
        end else begin
            south_r      <= inp_north;
            east_r       <= inp_west;
            valid_fwd_r  <= valid;
            last_fwd_r   <= last;
            signed_fwd_r <= signed_mode;
        end
    end

    // Accumulator: restarts from zero on capture so the next tile needs no bubble.
    always_ff @(posedge clk) begin
        if (rst || accum_reset) begin
            acc_r      <= {AW{1'b0}};
            sat_flag_r <= 1'b0;
        end else if (st_valid_s) begin
            if (st_last_s) begin
                acc_r <= {AW{1'b0}};
            end else begin
                acc_r <= sum_s;
            end
            sat_flag_r <= sat_flag_r | ((SATURATE != 0) & ovf_s);
        end else begin
            acc_r      <= acc_r;
            sat_flag_r <= sat_flag_r;
        end
    end

    // Hold register: capture beats the drain shift; lost data of either kind is flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_r       <= {AW{1'b0}};
            hold_valid_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else if (capture_s) begin
            hold_r       <= sum_s;
            hold_valid_r <= 1'b1;
            overrun_r    <= overrun_r | (hold_valid_r & ~shift_en) | (shift_en & drain_in_valid);
        end else if (shift_en) begin
            hold_r       <= drain_in;
            hold_valid_r <= drain_in_valid;
            overrun_r    <= overrun_r;
        end else begin
            hold_r       <= hold_r;
            hold_valid_r <= hold_valid_r;
            overrun_r    <= overrun_r;
        end
    end

    assign outp_south      = south_r;
    assign outp_east       = east_r;
    assign valid_out       = valid_fwd_r;
    assign last_out        = last_fwd_r;
    assign signed_out      = signed_fwd_r;
    assign drain_out       = hold_r;
    assign drain_out_valid = hold_valid_r;
    assign sat_flag        = sat_flag_r;
    assign overrun         = overrun_r;

endmodule

// File: tb/tb_pe_mac_db.sv
// Directed bench for pe_mac_db: a 32-bit PE, two 16-bit PEs (saturating/pipelined and
// wrapping/direct) sharing its stimulus, and a 4-PE drain column.
module tb_pe_mac_db;

    logic        clk = 1'b0;
    logic        rst, accum_reset, valid, last, sm, shift_en, col_shift;
    logic [7:0]  a, b;
    logic [31:0] zero32 = 32'd0;
    logic [15:0] zero16 = 16'd0;
    logic        zero1  = 1'b0;
    logic [7:0]  col_west = 8'd1;

    always #5 clk = ~clk;

    logic [7:0]  m_south, m_east;
    logic        m_vo, m_lo, m_so, m_dov, m_sat, m_ovr;
    logic [31:0] m_drain;

    pe_mac_db #(.DATA_WIDTH(8), .ACCUM_WIDTH(32), .PIPE_MUL(1), .SATURATE(1)) dut (
        .clk(clk), .rst(rst), .accum_reset(accum_reset), .valid(valid), .last(last),
        .signed_mode(sm), .inp_north(a), .inp_west(b), .outp_south(m_south), .outp_east(m_east),
        .valid_out(m_vo), .last_out(m_lo), .signed_out(m_so), .drain_in(zero32),
        .drain_in_valid(zero1), .shift_en(shift_en), .drain_out(m_drain),
        .drain_out_valid(m_dov), .sat_flag(m_sat), .overrun(m_ovr));

    // index 0: 16-bit saturating, pipelined; index 1: 16-bit wrapping, single-cycle
    logic [7:0]  s_south [2];
    logic [7:0]  s_east  [2];
    logic        s_vo [2], s_lo [2], s_so [2], s_dov [2], s_sat [2], s_ovr [2];
    logic [15:0] s_drain [2];

    for (genvar k = 0; k < 2; k++) begin : g_s16
        pe_mac_db #(.DATA_WIDTH(8), .ACCUM_WIDTH(16), .PIPE_MUL(1 - k), .SATURATE(1 - k)) u_pe (
            .clk(clk), .rst(rst), .accum_reset(accum_reset), .valid(valid), .last(last),
            .signed_mode(sm), .inp_north(a), .inp_west(b), .outp_south(s_south[k]),
            .outp_east(s_east[k]), .valid_out(s_vo[k]), .last_out(s_lo[k]), .signed_out(s_so[k]),
            .drain_in(zero16), .drain_in_valid(zero1), .shift_en(shift_en),
            .drain_out(s_drain[k]), .drain_out_valid(s_dov[k]), .sat_flag(s_sat[k]),
            .overrun(s_ovr[k]));
    end

    logic [7:0]  col_a [4];
    logic [7:0]  c_south [4];
    logic [7:0]  c_east  [4];
    logic        c_vo [4], c_lo [4], c_so [4], c_dov [4], c_sat [4], c_ovr [4];
    logic [31:0] c_drain [4];
    logic [31:0] c_din [4];
    logic        c_dinv [4];

    for (genvar g = 0; g < 4; g++) begin : g_col
        if (g == 0) begin : g_top
            assign c_din[g]  = 32'd0;
            assign c_dinv[g] = 1'b0;
        end else begin : g_mid
            assign c_din[g]  = c_drain[g-1];
            assign c_dinv[g] = c_dov[g-1];
        end
        pe_mac_db #(.DATA_WIDTH(8), .ACCUM_WIDTH(32), .PIPE_MUL(0), .SATURATE(1)) u_pe (
            .clk(clk), .rst(rst), .accum_reset(accum_reset), .valid(valid), .last(last),
            .signed_mode(sm), .inp_north(col_a[g]), .inp_west(col_west), .outp_south(c_south[g]),
            .outp_east(c_east[g]), .valid_out(c_vo[g]), .last_out(c_lo[g]), .signed_out(c_so[g]),
            .drain_in(c_din[g]), .drain_in_valid(c_dinv[g]), .shift_en(col_shift),
            .drain_out(c_drain[g]), .drain_out_valid(c_dov[g]), .sat_flag(c_sat[g]),
            .overrun(c_ovr[g]));
    end

    typedef struct {
        int              n;
        logic [3:0][7:0] ta;
        logic [3:0][7:0] tb;
        logic            tsm;
        logic [31:0]     exp32;
        logic            chk16;
        logic [15:0]     exp_sat16;
        logic [15:0]     exp_wrap16;
        logic            exp_satflag;
    } tile_t;

    tile_t tiles [6];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_column();
        for (int i = 0; i < 4; i++) col_a[i] = 8'(i + 1);
        sm = 1'b0; valid = 1'b1; last = 1'b1;
        tick();
        valid = 1'b0; last = 1'b0;
        tick();
    endtask

    initial begin
        // signed dot product 12 - 10 - 16256
        tiles[0] = '{3, {8'h00, 8'h7F, 8'hFE, 8'h03}, {8'h00, 8'h80, 8'h05, 8'h04}, 1'b1,
                     32'hFFFF_C082, 1'b1, 16'hC082, 16'hC082, 1'b0};
        tiles[1] = '{4, {4{8'hFF}}, {4{8'hFF}}, 1'b0, 32'd260100, 1'b0, 16'h0000, 16'h0000, 1'b0};
        tiles[2] = '{4, {4{8'hFF}}, {4{8'hFF}}, 1'b1, 32'd4, 1'b1, 16'd4, 16'd4, 1'b0};
        tiles[3] = '{1, {4{8'h80}}, {4{8'h80}}, 1'b0, 32'd16384, 1'b1, 16'h4000, 16'h4000, 1'b0};
        tiles[4] = '{2, {4{8'h80}}, {4{8'h80}}, 1'b1, 32'd32768, 1'b1, 16'h7FFF, 16'h8000, 1'b1};
        tiles[5] = '{3, {4{8'h7F}}, {4{8'h7F}}, 1'b1, 32'd48387, 1'b1, 16'h7FFF, 16'hBD03, 1'b1};

        rst = 1'b1; accum_reset = 1'b0; valid = 1'b0; last = 1'b0; sm = 1'b0;
        shift_en = 1'b0; col_shift = 1'b0; a = 8'h00; b = 8'h00;
        for (int i = 0; i < 4; i++) col_a[i] = 8'h00;
        tick(); tick();
        rst = 1'b0;
        check("rst_south", 32'(m_south), 32'd0);
        check("rst_east", 32'(m_east), 32'd0);
        check("rst_valid_out", 32'(m_vo), 32'd0);
        check("rst_drain_out", m_drain, 32'd0);
        check("rst_drain_valid", 32'(m_dov), 32'd0);
        check("rst_sat_flag", 32'(m_sat), 32'd0);
        check("rst_overrun", 32'(m_ovr), 32'd0);

        // forwarding is unconditional; accum_reset discards the valid pair
        a = 8'h5A; b = 8'hA5; valid = 1'b0; last = 1'b1; sm = 1'b1;
        tick();
        check("fwd_south", 32'(m_south), 32'h5A);
        check("fwd_east", 32'(m_east), 32'hA5);
        check("fwd_last", 32'(m_lo), 32'd1);
        check("fwd_signed", 32'(m_so), 32'd1);
        check("fwd_valid0", 32'(m_vo), 32'd0);
        a = 8'h3C; b = 8'hC3; valid = 1'b1; last = 1'b0; sm = 1'b0; accum_reset = 1'b1;
        tick();
        accum_reset = 1'b0; valid = 1'b0;
        check("fwd_south2", 32'(m_south), 32'h3C);
        check("fwd_valid1", 32'(m_vo), 32'd1);
        check("fwd_signed0", 32'(m_so), 32'd0);
        tick();

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < tiles[t].n; i++) begin
                valid = 1'b1; a = tiles[t].ta[i]; b = tiles[t].tb[i]; sm = tiles[t].tsm;
                last = (i == tiles[t].n - 1);
                tick();
            end
            valid = 1'b0; last = 1'b0;
            check($sformatf("tile%0d_dov_early", t), 32'(m_dov), 32'd0);
            tick();
            check($sformatf("tile%0d_dov", t), 32'(m_dov), 32'd1);
            check($sformatf("tile%0d_hold", t), m_drain, tiles[t].exp32);
            if (tiles[t].chk16) begin
                check($sformatf("tile%0d_hold16_sat", t), 32'(s_drain[0]), 32'(tiles[t].exp_sat16));
                check($sformatf("tile%0d_hold16_wrap", t), 32'(s_drain[1]), 32'(tiles[t].exp_wrap16));
                check($sformatf("tile%0d_satflag16", t), 32'(s_sat[0]), 32'(tiles[t].exp_satflag));
                check($sformatf("tile%0d_satflag_wrap", t), 32'(s_sat[1]), 32'd0);
            end
            shift_en = 1'b1;
            tick();
            shift_en = 1'b0;
            check($sformatf("tile%0d_drained", t), 32'(m_dov), 32'd0);
        end
        check("table_overrun", 32'(m_ovr), 32'd0);
        check("table_satflag32", 32'(m_sat), 32'd0);

        // accum_reset while the last pair sits in stage 1
        sm = 1'b1; valid = 1'b1; a = 8'd5; b = 8'd5; last = 1'b0;
        tick();
        a = 8'd2; b = 8'd3; last = 1'b1;
        tick();
        valid = 1'b0; last = 1'b0; accum_reset = 1'b1;
        tick();
        accum_reset = 1'b0;
        check("ar_no_capture", 32'(m_dov), 32'd0);
        check("ar_clears_satflag", 32'(s_sat[0]), 32'd0);
        tick();
        check("ar_no_capture_late", 32'(m_dov), 32'd0);
        valid = 1'b1; a = 8'd1; b = 8'd1; last = 1'b1;
        tick();
        valid = 1'b0; last = 1'b0;
        tick();
        check("ar_acc_zero", m_drain, 32'd1);
        shift_en = 1'b1;
        tick();
        shift_en = 1'b0;

        // back-to-back tiles, second capture without a shift
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("b2b_overrun_rst", 32'(m_ovr), 32'd0);
        sm = 1'b1; valid = 1'b1; a = 8'd2; b = 8'd5; last = 1'b1;
        tick();
        a = 8'd3; b = 8'd1; last = 1'b0;
        tick();
        check("b2b_hold_a", m_drain, 32'd10);
        check("b2b_overrun_a", 32'(m_ovr), 32'd0);
        a = 8'd4; b = 8'd1; last = 1'b1;
        tick();
        valid = 1'b0; last = 1'b0;
        check("b2b_hold_a_kept", m_drain, 32'd10);
        tick();
        check("b2b_hold_b", m_drain, 32'd7);
        check("b2b_overrun_b", 32'(m_ovr), 32'd1);

        // drain column
        rst = 1'b1;
        tick();
        rst = 1'b0;
        load_column();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("chain_val%0d", k), c_drain[3], 32'(4 - k));
            check($sformatf("chain_vld%0d", k), 32'(c_dov[3]), 32'd1);
            col_shift = 1'b1;
            tick();
            col_shift = 1'b0;
        end
        check("chain_empty", 32'(c_dov[3]), 32'd0);
        check("chain_overrun", 32'(c_ovr[3]), 32'd0);

        // rst in the middle of a drain
        load_column();
        col_shift = 1'b1;
        tick();
        check("drain_mid", c_drain[3], 32'd3);
        rst = 1'b1; a = 8'h5A; b = 8'hA5; valid = 1'b1; last = 1'b1;
        tick();
        rst = 1'b0; valid = 1'b0; last = 1'b0; col_shift = 1'b0;
        check("rstd_chain_data", c_drain[3], 32'd0);
        check("rstd_chain_valid", 32'(c_dov[3]), 32'd0);
        check("rstd_south", 32'(m_south), 32'd0);
        check("rstd_valid_out", 32'(m_vo), 32'd0);
        check("rstd_last_out", 32'(m_lo), 32'd0);
        check("rstd_overrun", 32'(m_ovr), 32'd0);
        check("rstd_drain_valid", 32'(m_dov), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
